// File: rtl/dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : dmem_arbiter
// Two-port valid/ready arbiter and sequencer in front of the data RAM, with
// alignment/funct3/range checking and a registered response per transaction.
// Option   : DMEM_ARB_RR_EN selects round-robin arbitration (default: port 0
//            has fixed priority).
// Revision : 1.0 - initial release
// =============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_wen,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [2:0]  p0_req_funct3,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_wen,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [2:0]  p1_req_funct3,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [2:0]  ram_funct3,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_owner;
  logic        r_wen;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;

  logic        w_any_valid;
  logic        w_grant1;
  logic        w_accept;
  logic        w_owner_resp_ready;
  logic        w_sel_wen;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [2:0]  w_sel_funct3;
  logic        w_fmt_err;
  logic        w_range_err;

  assign w_any_valid = p0_req_valid | p1_req_valid;
  assign w_accept    = (r_state == c_ST_IDLE) & w_any_valid & ~rst;

`ifdef DMEM_ARB_RR_EN
  logic r_last_grant;

  // On contention the port that was not granted last time wins.
  assign w_grant1 = p1_req_valid & (~p0_req_valid | ~r_last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
    end
  end
`else
  assign w_grant1 = p1_req_valid & ~p0_req_valid;
`endif

  assign w_sel_wen    = w_grant1 ? p1_req_wen    : p0_req_wen;
  assign w_sel_addr   = w_grant1 ? p1_req_addr   : p0_req_addr;
  assign w_sel_wdata  = w_grant1 ? p1_req_wdata  : p0_req_wdata;
  assign w_sel_funct3 = w_grant1 ? p1_req_funct3 : p0_req_funct3;
  assign w_range_err  = |w_sel_addr[31:ADDR_W];

  always_comb begin
    w_fmt_err = 1'b0;
    case (w_sel_funct3)
      3'b000, 3'b100: w_fmt_err = 1'b0;
      3'b001, 3'b101: w_fmt_err = w_sel_addr[0];
      3'b010:         w_fmt_err = |w_sel_addr[1:0];
      default:        w_fmt_err = 1'b1;
    endcase
  end

  assign w_owner_resp_ready = r_owner ? p1_resp_ready : p0_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_any_valid) w_state_nxt = c_ST_ACCESS;
      c_ST_ACCESS: w_state_nxt = c_ST_RESP;
      c_ST_RESP:   if (w_owner_resp_ready) w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= 1'b0;
      r_wen    <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant1;
        r_wen    <= w_sel_wen;
        r_err    <= w_fmt_err | w_range_err;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
        r_funct3 <= w_sel_funct3;
      end
      if (r_state == c_ST_ACCESS) begin
        r_rdata <= (r_err | r_wen) ? '0 : ram_rdata;
      end
    end
  end

  always_comb begin
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    p0_resp_rdata = '0;
    p1_resp_rdata = '0;
    p0_resp_err   = 1'b0;
    p1_resp_err   = 1'b0;
    ram_wen       = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    ram_funct3    = '0;
    case (r_state)
      c_ST_IDLE: begin
        p0_req_ready = ~rst & w_any_valid & ~w_grant1;
        p1_req_ready = ~rst & w_grant1;
      end
      c_ST_ACCESS: begin
        // Reset during the access cycle must not leave a partial store behind.
        ram_wen    = r_wen & ~r_err & ~rst;
        ram_addr   = r_addr;
        ram_wdata  = r_wdata;
        ram_funct3 = r_funct3;
      end
      c_ST_RESP: begin
        if (!rst) begin
          if (r_owner) begin
            p1_resp_valid = 1'b1;
            p1_resp_rdata = r_rdata;
            p1_resp_err   = r_err;
          end else begin
            p0_resp_valid = 1'b1;
            p0_resp_rdata = r_rdata;
            p0_resp_err   = r_err;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Testbench for dmem_arbiter: directed scenarios plus randomized two-port
// traffic checked against a byte-array memory model and timing rules.
module tb_dmem_arbiter;

  localparam int ADDR_W = 16;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_f3     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [2:0]  ram_funct3;
  logic [31:0] ram_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int last_acc    = 1;

  logic [7:0]  ram     [0:65535] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
  logic [15:0] ra;
  logic [31:0] rword;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(req_valid[0]), .p0_req_ready(req_ready[0]), .p0_req_wen(req_wen[0]),
    .p0_req_addr(req_addr[0]), .p0_req_wdata(req_wdata[0]), .p0_req_funct3(req_f3[0]),
    .p0_resp_valid(resp_valid[0]), .p0_resp_ready(resp_ready[0]),
    .p0_resp_rdata(resp_rdata[0]), .p0_resp_err(resp_err[0]),
    .p1_req_valid(req_valid[1]), .p1_req_ready(req_ready[1]), .p1_req_wen(req_wen[1]),
    .p1_req_addr(req_addr[1]), .p1_req_wdata(req_wdata[1]), .p1_req_funct3(req_f3[1]),
    .p1_resp_valid(resp_valid[1]), .p1_resp_ready(resp_ready[1]),
    .p1_resp_rdata(resp_rdata[1]), .p1_resp_err(resp_err[1]),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_funct3(ram_funct3), .ram_rdata(ram_rdata)
  );

  // External RAM: combinational extended read, synchronous sized write.
  always_comb begin
    ra    = ram_addr[15:0];
    rword = {ram[ra + 16'd3], ram[ra + 16'd2], ram[ra + 16'd1], ram[ra]};
    case (ram_funct3)
      3'b000:  ram_rdata = {{24{rword[7]}}, rword[7:0]};
      3'b100:  ram_rdata = {24'h0, rword[7:0]};
      3'b001:  ram_rdata = {{16{rword[15]}}, rword[15:0]};
      3'b101:  ram_rdata = {16'h0, rword[15:0]};
      default: ram_rdata = rword;
    endcase
  end

  always @(posedge clk) begin
    if (ram_wen) begin
      ram[ram_addr[15:0]] <= ram_wdata[7:0];
      if (ram_funct3[1:0] != 2'b00) ram[ram_addr[15:0] + 16'd1] <= ram_wdata[15:8];
      if (ram_funct3[1:0] == 2'b10) begin
        ram[ram_addr[15:0] + 16'd2] <= ram_wdata[23:16];
        ram[ram_addr[15:0] + 16'd3] <= ram_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return {ram[a + 16'd3], ram[a + 16'd2], ram[a + 16'd1], ram[a]};
  endfunction

  // Reference: access rules applied to a plain byte array.
  task automatic model_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           ((addr % size) != 0) || (addr >= (32'd1 << ADDR_W));
    rd = '0;
    if (err) return;
    if (wen) begin
      for (int i = 0; i < size; i++) ref_mem[16'(addr + i)] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[16'(addr + i)]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
      rd = v;
    end
  endtask

  // Issues one request on port p; returns observed timing and response.
  task automatic do_txn(input int p, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output int wait_cyc, output int lat, output logic [31:0] rdata,
                        output logic err, output logic acc_wen, output logic [31:0] acc_addr);
    logic [31:0] mrd;
    logic        merr;
    req_wen[p] = wen; req_addr[p] = addr; req_wdata[p] = wdata; req_f3[p] = f3;
    req_valid[p] = 1'b1;
    wait_cyc = 0; lat = -1; rdata = '0; err = 1'b0; acc_wen = 1'b0; acc_addr = '0;
    #1;
    while (!req_ready[p] && wait_cyc < 20) begin
      @(posedge clk); #2; wait_cyc++;
    end
    if (!req_ready[p]) begin
      req_valid[p] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    model_access(wen, addr, wdata, f3, mrd, merr);
    last_acc = p;
    @(posedge clk); #1;
    req_valid[p] = 1'b0; req_addr[p] = $urandom; req_wdata[p] = $urandom;
    req_f3[p] = 3'($urandom); req_wen[p] = ~wen;
    #1;
    lat = 1; acc_wen = ram_wen; acc_addr = ram_addr;
    while (!resp_valid[p] && lat < 20) begin
      @(posedge clk); #2; lat++;
    end
    rdata = resp_rdata[p]; err = resp_err[p];
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b1; req_wen[p] = 1'b0; req_addr[p] = 32'h100;
      req_wdata[p] = '0; req_f3[p] = 3'b010; resp_ready[p] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (req_ready[0] !== 1'b0 || req_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b%b expected 00", req_ready[1], req_ready[0]);
    end
    vectors++;
    if (resp_valid[0] !== 1'b0 || resp_valid[1] !== 1'b0 || resp_err[0] !== 1'b0 ||
        resp_err[1] !== 1'b0 || resp_rdata[0] !== 32'h0 || resp_rdata[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got valid=%b%b err=%b%b rdata0=%h rdata1=%h expected all 0",
               resp_valid[1], resp_valid[0], resp_err[1], resp_err[0], resp_rdata[0], resp_rdata[1]);
    end
    vectors++;
    if (ram_wen !== 1'b0 || ram_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ram: got wen=%b addr=%h expected 0/0", ram_wen, ram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid[0] = 1'b0; req_valid[1] = 1'b0; last_acc = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw;
    int w, l;
    logic [31:0] rd, aa;
    logic e, aw;
    do_txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, w, l, rd, e, aw, aa);
    vectors++;
    if (w != 0 || l != 2) begin
      miscompares++;
      $display("FAIL sw_timing: got wait=%0d lat=%0d expected 0/2", w, l);
    end
    vectors++;
    if (aw !== 1'b1 || aa !== 32'h100 || rd !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_access: got wen=%b addr=%h rdata=%h err=%b expected 1/100/0/0", aw, aa, rd, e);
    end
    vectors++;
    if (ram_word(16'h100) !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_ram: got %h expected deadbeef", ram_word(16'h100));
    end
    do_txn(0, 1'b0, 32'h100, 32'h0, 3'b010, w, l, rd, e, aw, aa);
    vectors++;
    if (w != 0 || l != 2 || rd !== 32'hDEADBEEF || e !== 1'b0 || aw !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_resp: got wait=%0d lat=%0d rdata=%h err=%b wen=%b expected 0/2/deadbeef/0/0",
               w, l, rd, e, aw);
    end
  endtask

  task automatic test_byte;
    int w, l;
    logic [31:0] rd, aa;
    logic e, aw;
    do_txn(1, 1'b1, 32'h103, 32'h00000080, 3'b000, w, l, rd, e, aw, aa);
    vectors++;
    if (ram_word(16'h100) !== 32'h80ADBEEF || e !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_ram: got %h err=%b expected 80adbeef/0", ram_word(16'h100), e);
    end
    do_txn(1, 1'b0, 32'h103, 32'h0, 3'b000, w, l, rd, e, aw, aa);
    vectors++;
    if (rd !== 32'hFFFFFF80 || e !== 1'b0 || l != 2) begin
      miscompares++;
      $display("FAIL lb: got %h err=%b lat=%0d expected ffffff80/0/2", rd, e, l);
    end
    do_txn(1, 1'b0, 32'h103, 32'h0, 3'b100, w, l, rd, e, aw, aa);
    vectors++;
    if (rd !== 32'h00000080 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL lbu: got %h err=%b expected 00000080/0", rd, e);
    end
  endtask

  task automatic test_errors;
    int w, l;
    logic [31:0] rd, aa;
    logic e, aw;
    do_txn(0, 1'b0, 32'h102, 32'h0, 3'b010, w, l, rd, e, aw, aa);
    vectors++;
    if (e !== 1'b1 || rd !== 32'h0 || l != 2) begin
      miscompares++;
      $display("FAIL lw_misaligned: got err=%b rdata=%h lat=%0d expected 1/0/2", e, rd, l);
    end
    do_txn(1, 1'b1, 32'h101, 32'h00001234, 3'b001, w, l, rd, e, aw, aa);
    vectors++;
    if (e !== 1'b1 || aw !== 1'b0 || ram_word(16'h100) !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL sh_misaligned: got err=%b wen=%b word=%h expected 1/0/80adbeef",
               e, aw, ram_word(16'h100));
    end
    do_txn(0, 1'b0, 32'h100, 32'h0, 3'b011, w, l, rd, e, aw, aa);
    vectors++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL funct3_011: got err=%b rdata=%h expected 1/0", e, rd);
    end
    do_txn(1, 1'b0, 32'h00010000, 32'h0, 3'b010, w, l, rd, e, aw, aa);
    vectors++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL out_of_range_load: got err=%b rdata=%h expected 1/0", e, rd);
    end
    do_txn(0, 1'b1, 32'h00010100, 32'h11223344, 3'b010, w, l, rd, e, aw, aa);
    vectors++;
    if (e !== 1'b1 || aw !== 1'b0 || ram_word(16'h100) !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL out_of_range_store: got err=%b wen=%b word=%h expected 1/0/80adbeef",
               e, aw, ram_word(16'h100));
    end
  endtask

  task automatic test_contention;
    int n, cyc, exp_g, got_g;
    logic [31:0] mrd;
    logic merr;
    for (int p = 0; p < 2; p++) begin
      req_wen[p] = 1'b0; req_addr[p] = 32'h100; req_f3[p] = 3'b010; req_valid[p] = 1'b1;
    end
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      #1;
      if (req_ready[0] || req_ready[1]) begin
        got_g = req_ready[1] ? 1 : 0;
        exp_g = RR ? 1 - last_acc : 0;
        vectors++;
        if ((req_ready[0] && req_ready[1]) || got_g != exp_g) begin
          miscompares++;
          $display("FAIL contention_grant%0d: got ready=%b%b expected port %0d",
                   n, req_ready[1], req_ready[0], exp_g);
        end
        model_access(1'b0, 32'h100, 32'h0, 3'b010, mrd, merr);
        last_acc = exp_g;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d grants expected 4", n);
    end
    req_valid[0] = 1'b0;
    cyc = 0;
    #1;
    while (!req_ready[1] && cyc < 10) begin
      @(posedge clk); #2; cyc++;
    end
    vectors++;
    if (req_ready[1] !== 1'b1 || req_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL contention_port1_served: got ready=%b%b expected 10", req_ready[1], req_ready[0]);
    end
    last_acc = 1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_rd, mrd;
    logic exp_err, merr;
    int cyc;
    model_access(1'b0, 32'h100, 32'h0, 3'b010, exp_rd, exp_err);
    resp_ready[0] = 1'b0;
    req_wen[0] = 1'b0; req_addr[0] = 32'h100; req_f3[0] = 3'b010; req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: got ready0=%b expected 1", req_ready[0]);
    end
    last_acc = 0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_wen[1] = 1'b1; req_addr[1] = 32'h104; req_wdata[1] = 32'h5555AAAA;
    req_f3[1] = 3'b010; req_valid[1] = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== exp_rd || resp_err[0] !== exp_err ||
          req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b ready1=%b expected 1/%h/%b/0",
                 i, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[1], exp_rd, exp_err);
      end
      @(posedge clk); #1;
      if (i == 4) resp_ready[0] = 1'b1;
      #1;
    end
    vectors++;
    if (resp_valid[0] !== 1'b1 || req_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got valid0=%b ready1=%b expected 1/0", resp_valid[0], req_ready[1]);
    end
    @(posedge clk); #2;
    vectors++;
    if (resp_valid[0] !== 1'b0 || req_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next: got valid0=%b ready1=%b expected 0/1", resp_valid[0], req_ready[1]);
    end
    model_access(1'b1, 32'h104, 32'h5555AAAA, 3'b010, mrd, merr);
    last_acc = 1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    cyc = 0;
    #1;
    while (!resp_valid[1] && cyc < 10) begin
      @(posedge clk); #2; cyc++;
    end
    vectors++;
    if (resp_valid[1] !== 1'b1 || resp_err[1] !== 1'b0 || resp_rdata[1] !== 32'h0 ||
        ram_word(16'h104) !== 32'h5555AAAA) begin
      miscompares++;
      $display("FAIL bp_port1_store: got valid=%b err=%b rdata=%h word=%h expected 1/0/0/5555aaaa",
               resp_valid[1], resp_err[1], resp_rdata[1], ram_word(16'h104));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int w, l;
    logic [31:0] rd, aa;
    logic e, aw;
    do_txn(0, 1'b1, 32'h200, 32'hCAFEF00D, 3'b010, w, l, rd, e, aw, aa);
    req_wen[0] = 1'b1; req_addr[0] = 32'h200; req_wdata[0] = 32'h12345678;
    req_f3[0] = 3'b010; req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_accept: got ready0=%b expected 1", req_ready[0]);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (ram_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_ram_wen: got %b expected 0", ram_wen);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_acc = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (resp_valid[0] !== 1'b0 || resp_valid[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_no_resp%0d: got valid=%b%b expected 00", i, resp_valid[1], resp_valid[0]);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (ram_word(16'h200) !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL rstmid_ram: got %h expected cafef00d", ram_word(16'h200));
    end
    do_txn(0, 1'b0, 32'h200, 32'h0, 3'b010, w, l, rd, e, aw, aa);
    vectors++;
    if (w != 0 || l != 2 || rd !== 32'hCAFEF00D || e !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_next: got wait=%0d lat=%0d rdata=%h err=%b expected 0/2/cafef00d/0",
               w, l, rd, e);
    end
  endtask

  task automatic test_random(input int ncyc);
    logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  ill   [3] = '{3'b011, 3'b110, 3'b111};
    bit          pend  [2] = '{1'b0, 1'b0};
    bit          q_v = 1'b0;
    int          q_p = 0, q_age = 0, win = 0;
    logic        q_wen = 1'b0, q_err = 1'b0;
    logic [31:0] q_addr = '0, q_rd = '0, a;
    logic [2:0]  f;
    logic [1:0]  exp_rdy, exp_rv;
    logic        exp_wen;
    for (int c = 0; c < ncyc; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(2) == 0) begin
            f = ($urandom_range(9) == 0) ? ill[$urandom_range(2)] : legal[$urandom_range(4)];
            a = 32'h300 + 32'($urandom_range(63));
            if ($urandom_range(3) != 0)
              a = a & ((f[1:0] == 2'b10) ? ~32'd3 : (f[1:0] == 2'b01) ? ~32'd1 : ~32'd0);
            if ($urandom_range(15) == 0) a = a | (32'd1 << $urandom_range(31, 16));
            req_wen[p] = 1'($urandom); req_addr[p] = a; req_wdata[p] = $urandom;
            req_f3[p] = f; req_valid[p] = 1'b1; pend[p] = 1'b1;
          end else begin
            req_valid[p] = 1'b0;
          end
        end
        resp_ready[p] = ($urandom_range(3) != 0);
      end
      #1;
      exp_rdy = 2'b00;
      if (!q_v && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) win = RR ? 1 - last_acc : 0;
        else win = pend[0] ? 0 : 1;
        exp_rdy[win] = 1'b1;
      end
      vectors++;
      if ({req_ready[1], req_ready[0]} !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_ready c%0d: got %b%b expected %b", c, req_ready[1], req_ready[0], exp_rdy);
      end
      exp_rv = 2'b00;
      if (q_v && q_age >= 2) exp_rv[q_p] = 1'b1;
      vectors++;
      if ({resp_valid[1], resp_valid[0]} !== exp_rv) begin
        miscompares++;
        $display("FAIL rand_resp_valid c%0d: got %b%b expected %b", c, resp_valid[1], resp_valid[0], exp_rv);
      end
      if (q_v && q_age >= 2) begin
        vectors++;
        if (resp_rdata[q_p] !== q_rd || resp_err[q_p] !== q_err) begin
          miscompares++;
          $display("FAIL rand_resp_data c%0d port%0d: got %h/%b expected %h/%b",
                   c, q_p, resp_rdata[q_p], resp_err[q_p], q_rd, q_err);
        end
      end
      exp_wen = q_v && q_age == 1 && q_wen && !q_err;
      vectors++;
      if (ram_wen !== exp_wen || ram_addr !== ((q_v && q_age == 1) ? q_addr : 32'h0)) begin
        miscompares++;
        $display("FAIL rand_ram c%0d: got wen=%b addr=%h expected wen=%b", c, ram_wen, ram_addr, exp_wen);
      end
      if (q_v) begin
        if (q_age >= 2 && resp_ready[q_p]) q_v = 1'b0;
        else q_age++;
      end else if (exp_rdy != 2'b00) begin
        q_v = 1'b1; q_p = win; q_age = 1; q_wen = req_wen[win]; q_addr = req_addr[win];
        model_access(req_wen[win], req_addr[win], req_wdata[win], req_f3[win], q_rd, q_err);
        pend[win] = 1'b0;
        last_acc = win;
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_sw_lw();
    test_byte();
    test_errors();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random(500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
